// File: rtl/rotator.sv
`default_nettype none
// ============================================================================
// Module   : rotator
// Purpose  : Transmit-side complex rotator. Multiplies each I/Q sample by
//            e^(+j*theta). theta comes from an internal phase accumulator.
//            The phase is sent to an external DDS, and the returned cos/sin
//            are realigned with the sample stream. The result is rounded
//            half-up and saturated back to WIDTH bits.
// Ports    :
//   clk           sole clock
//   rst_n         asynchronous active-low reset
//   freq_word     phase increment applied per valid sample
//   phase_offset  static offset added to the accumulator on output
//   phase_load    pulse: clears the accumulator
//   valid_in      qualifies din_i / din_q
//   din_i, din_q  signed Q1.(WIDTH-1) baseband sample
//   phase_out     phase request to the DDS
//   phase_valid   qualifies phase_out
//   cos_in,sin_in signed Q1.(DDS_WIDTH-1) DDS result, DDS_LAT after phase_out
//   valid_out     qualifies dout_i / dout_q
//   dout_i,dout_q rotated sample, valid DDS_LAT+3 cycles after valid_in
// Revision : 1.0 - initial release
// ============================================================================
module rotator #(
    parameter int WIDTH       = 16,
    parameter int DDS_WIDTH   = 16,
    parameter int PHASE_WIDTH = 32,
    parameter int DDS_LAT     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic        [PHASE_WIDTH-1:0] freq_word,
    input  logic        [PHASE_WIDTH-1:0] phase_offset,
    input  logic                          phase_load,
    input  logic                          valid_in,
    input  logic signed [WIDTH-1:0]       din_i,
    input  logic signed [WIDTH-1:0]       din_q,
    output logic        [PHASE_WIDTH-1:0] phase_out,
    output logic                          phase_valid,
    input  logic signed [DDS_WIDTH-1:0]   cos_in,
    input  logic signed [DDS_WIDTH-1:0]   sin_in,
    output logic                          valid_out,
    output logic signed [WIDTH-1:0]       dout_i,
    output logic signed [WIDTH-1:0]       dout_q
);

    localparam int c_PW = WIDTH + DDS_WIDTH;   // product width
    localparam int c_SW = c_PW + 1;            // sum width

    // Rounding constant 2^(DDS_WIDTH-2): adding it before the shift gives round-half-up.
    localparam logic signed [c_SW-1:0] c_RND =
        {{(c_SW-DDS_WIDTH+1){1'b0}}, 1'b1, {(DDS_WIDTH-2){1'b0}}};
    localparam logic signed [c_SW-1:0] c_MAX =
        {{(c_SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [c_SW-1:0] c_MIN =
        {{(c_SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // Phase accumulator and DDS request
    // ------------------------------------------------------------------
    logic [PHASE_WIDTH-1:0] r_acc;
    logic [PHASE_WIDTH-1:0] r_phase;
    logic                   r_phase_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_phase   <= '0;
            r_phase_v <= 1'b0;
        end else begin
            r_phase_v <= valid_in;
            if (valid_in) begin
                // The current sample uses the pre-clear accumulator value.
                r_phase <= r_acc + phase_offset;
                r_acc   <= (phase_load ? '0 : r_acc) + freq_word;
            end else if (phase_load) begin
                r_acc <= '0;
            end
        end
    end

    assign phase_out   = r_phase;
    assign phase_valid = r_phase_v;

    // ------------------------------------------------------------------
    // Sample delay line. The line is DDS_LAT+1 deep, so the last stage meets
    // the cos/sin that the DDS produced for that sample's own phase.
    // ------------------------------------------------------------------
    logic signed [WIDTH-1:0] r_dly_i [0:DDS_LAT];
    logic signed [WIDTH-1:0] r_dly_q [0:DDS_LAT];
    logic        [DDS_LAT:0] r_dly_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly_v <= '0;
            for (int k = 0; k <= DDS_LAT; k++) begin
                r_dly_i[k] <= '0;
                r_dly_q[k] <= '0;
            end
        end else begin
            r_dly_v[0] <= valid_in;
            r_dly_i[0] <= din_i;
            r_dly_q[0] <= din_q;
            for (int k = 1; k <= DDS_LAT; k++) begin
                r_dly_v[k] <= r_dly_v[k-1];
                r_dly_i[k] <= r_dly_i[k-1];
                r_dly_q[k] <= r_dly_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Multiply stage. cos/sin are only meaningful on delayed-valid cycles.
    // ------------------------------------------------------------------
    logic signed [c_PW-1:0] r_p_ic;
    logic signed [c_PW-1:0] r_p_qs;
    logic signed [c_PW-1:0] r_p_is;
    logic signed [c_PW-1:0] r_p_qc;
    logic                   r_mv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_ic <= '0;
            r_p_qs <= '0;
            r_p_is <= '0;
            r_p_qc <= '0;
            r_mv   <= 1'b0;
        end else begin
            r_mv <= r_dly_v[DDS_LAT];
            if (r_dly_v[DDS_LAT]) begin
                r_p_ic <= c_PW'(r_dly_i[DDS_LAT]) * c_PW'(cos_in);
                r_p_qs <= c_PW'(r_dly_q[DDS_LAT]) * c_PW'(sin_in);
                r_p_is <= c_PW'(r_dly_i[DDS_LAT]) * c_PW'(sin_in);
                r_p_qc <= c_PW'(r_dly_q[DDS_LAT]) * c_PW'(cos_in);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sum, round, scale and saturate
    // ------------------------------------------------------------------
    logic signed [c_SW-1:0] w_yi_sum;
    logic signed [c_SW-1:0] w_yq_sum;
    logic signed [c_SW-1:0] w_yi_sh;
    logic signed [c_SW-1:0] w_yq_sh;

    assign w_yi_sum = c_SW'(r_p_ic) - c_SW'(r_p_qs);
    assign w_yq_sum = c_SW'(r_p_is) + c_SW'(r_p_qc);
    assign w_yi_sh  = (w_yi_sum + c_RND) >>> (DDS_WIDTH - 1);
    assign w_yq_sh  = (w_yq_sum + c_RND) >>> (DDS_WIDTH - 1);

    function automatic logic signed [WIDTH-1:0] f_sat(input logic signed [c_SW-1:0] v);
        logic signed [WIDTH-1:0] r;
        if (v > c_MAX) begin
            r = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (v < c_MIN) begin
            r = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            r = v[WIDTH-1:0];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            dout_i    <= '0;
            dout_q    <= '0;
        end else begin
            valid_out <= r_mv;
            if (r_mv) begin
                dout_i <= f_sat(w_yi_sh);
                dout_q <= f_sat(w_yq_sh);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rotator.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotator
// Purpose  : Directed self-checking bench for rotator. It uses a behavioural
//            2-cycle DDS. The DDS either returns forced cos/sin values or a
//            quadrant table taken from phase_out[31:30].
// Revision : 1.0 - initial release
// ============================================================================
module tb_rotator;

    logic               clk = 1'b0;
    logic               rst_n;
    logic        [31:0] freq_word;
    logic        [31:0] phase_offset;
    logic               phase_load;
    logic               valid_in;
    logic signed [15:0] din_i;
    logic signed [15:0] din_q;
    logic        [31:0] phase_out;
    logic               phase_valid;
    logic signed [15:0] cos_in;
    logic signed [15:0] sin_in;
    logic               valid_out;
    logic signed [15:0] dout_i;
    logic signed [15:0] dout_q;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    rotator #(
        .WIDTH       (16),
        .DDS_WIDTH   (16),
        .PHASE_WIDTH (32),
        .DDS_LAT     (2)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .freq_word    (freq_word),
        .phase_offset (phase_offset),
        .phase_load   (phase_load),
        .valid_in     (valid_in),
        .din_i        (din_i),
        .din_q        (din_q),
        .phase_out    (phase_out),
        .phase_valid  (phase_valid),
        .cos_in       (cos_in),
        .sin_in       (sin_in),
        .valid_out    (valid_out),
        .dout_i       (dout_i),
        .dout_q       (dout_q)
    );

    // ------------------------------------------------------------------
    // Behavioural DDS with a latency of 2 cycles
    // ------------------------------------------------------------------
    logic               r_frc;
    logic signed [15:0] r_fc;
    logic signed [15:0] r_fs;
    logic signed [15:0] r_d1c, r_d1s, r_d2c, r_d2s;

    function automatic logic signed [15:0] f_qcos(input logic [1:0] q);
        case (q)
            2'd0:    return 16'sd32767;
            2'd2:    return -16'sd32768;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic logic signed [15:0] f_qsin(input logic [1:0] q);
        case (q)
            2'd1:    return 16'sd32767;
            2'd3:    return -16'sd32768;
            default: return 16'sd0;
        endcase
    endfunction

    always @(posedge clk) begin
        r_d1c <= r_frc ? r_fc : f_qcos(phase_out[31:30]);
        r_d1s <= r_frc ? r_fs : f_qsin(phase_out[31:30]);
        r_d2c <= r_d1c;
        r_d2s <= r_d1s;
    end

    assign cos_in = r_d2c;
    assign sin_in = r_d2s;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one isolated sample, then check that the output appears exactly 4 edges later.
    task automatic send_one(input string tag, input logic signed [15:0] di,
                            input logic signed [15:0] dq,
                            input logic signed [15:0] ei,
                            input logic signed [15:0] eq);
        valid_in = 1'b1;
        din_i    = di;
        din_q    = dq;
        step();
        valid_in = 1'b0;
        din_i    = 16'sd0;
        din_q    = 16'sd0;
        repeat (3) step();
        chk({tag, "_early_v"}, 64'(valid_out), 64'd0);
        step();
        chk({tag, "_v"}, 64'(valid_out), 64'd1);
        chk({tag, "_i"}, dout_i, ei);
        chk({tag, "_q"}, dout_q, eq);
        step();
        chk({tag, "_after_v"}, 64'(valid_out), 64'd0);
    endtask

    logic        [31:0] wrap_ph [5] = '{32'h1000_0000, 32'h5000_0000, 32'h9000_0000,
                                        32'hD000_0000, 32'h1000_0000};
    logic signed [15:0] wrap_i  [5] = '{16'sd10000, 16'sd0, -16'sd10000, 16'sd0, 16'sd10000};
    logic signed [15:0] wrap_q  [5] = '{16'sd0, 16'sd10000, 16'sd0, -16'sd10000, 16'sd0};

    logic               gap_v   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic               gap_ld  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic signed [15:0] gap_di  [5] = '{16'sd1000, 16'sd7777, 16'sd2000, 16'sd3000, 16'sd4000};
    logic        [31:0] gap_ph  [5] = '{32'h10, 32'h10, 32'h110, 32'h210, 32'h110};
    logic signed [15:0] gap_oi  [5] = '{16'sd1000, 16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000};

    initial begin
        rst_n        = 1'b0;
        valid_in     = 1'b0;
        phase_load   = 1'b0;
        freq_word    = 32'd0;
        phase_offset = 32'd0;
        din_i        = 16'sd0;
        din_q        = 16'sd0;
        r_frc        = 1'b1;
        r_fc         = 16'sd32767;
        r_fs         = 16'sd0;
        repeat (3) step();

        chk("rst_phase_out", phase_out, 64'd0);
        chk("rst_phase_valid", 64'(phase_valid), 64'd0);
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_dout_i", dout_i, 64'sd0);
        chk("rst_dout_q", dout_q, 64'sd0);

        rst_n = 1'b1;
        step();

        // Identity, quadrature and full-scale saturation with forced DDS values
        send_one("identity", 16'sd16384, -16'sd8192, 16'sd16384, -16'sd8192);
        r_fc = 16'sd0;
        r_fs = 16'sd32767;
        repeat (3) step();
        send_one("quadrature", 16'sd10000, 16'sd0, 16'sd0, 16'sd10000);
        r_fc = -16'sd32768;
        r_fs = 16'sd0;
        repeat (3) step();
        send_one("saturate", -16'sd32768, -16'sd32768, 16'sd32767, 16'sd32767);

        // Accumulator wrap, back-to-back, with quadrant-table DDS alignment
        r_frc        = 1'b0;
        freq_word    = 32'h4000_0000;
        phase_offset = 32'h1000_0000;
        phase_load   = 1'b1;
        step();
        phase_load   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 5) begin
                valid_in = 1'b1;
                din_i    = 16'sd10000;
                din_q    = 16'sd0;
            end else begin
                valid_in = 1'b0;
            end
            step();
            if (i < 5) chk("wrap_phase", phase_out, 64'(wrap_ph[i]));
            if (i == 3) chk("wrap_early_v", 64'(valid_out), 64'd0);
            if (i >= 4 && i < 9) begin
                chk("wrap_v", 64'(valid_out), 64'd1);
                chk("wrap_i", dout_i, wrap_i[i-4]);
                chk("wrap_q", dout_q, wrap_q[i-4]);
            end
            if (i == 9) begin
                chk("wrap_tail_v", 64'(valid_out), 64'd0);
                chk("wrap_hold_i", dout_i, 64'sd10000);
            end
        end

        // Gapped valid with phase_load on the third valid sample
        freq_word    = 32'h100;
        phase_offset = 32'h10;
        phase_load   = 1'b1;
        step();
        phase_load   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 5) begin
                valid_in   = gap_v[i];
                phase_load = gap_ld[i];
                din_i      = gap_di[i];
                din_q      = 16'sd0;
            end else begin
                valid_in   = 1'b0;
                phase_load = 1'b0;
            end
            step();
            if (i < 5) begin
                chk("gap_phase", phase_out, 64'(gap_ph[i]));
                chk("gap_pvalid", 64'(phase_valid), 64'(gap_v[i]));
            end
            if (i >= 4 && i < 9) begin
                chk("gap_v", 64'(valid_out), 64'(gap_v[i-4]));
                chk("gap_i", dout_i, gap_oi[i-4]);
            end
        end

        // Asynchronous reset with samples in flight
        freq_word    = 32'h4000_0000;
        phase_offset = 32'h1234;
        phase_load   = 1'b1;
        step();
        phase_load   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1;
            din_i    = 16'sd10000;
            din_q    = 16'sd0;
            step();
        end
        valid_in = 1'b0;
        chk("ar_pre_i", dout_i, 64'sd10000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_phase_out", phase_out, 64'd0);
        chk("ar_phase_valid", 64'(phase_valid), 64'd0);
        chk("ar_valid_out", 64'(valid_out), 64'd0);
        chk("ar_dout_i", dout_i, 64'sd0);
        chk("ar_dout_q", dout_q, 64'sd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("ar_flushed_v", 64'(valid_out), 64'd0);
        end
        valid_in = 1'b1;
        din_i    = 16'sd10000;
        din_q    = 16'sd0;
        step();
        valid_in = 1'b0;
        chk("ar_first_phase", phase_out, 64'h1234);
        repeat (4) step();
        chk("ar_first_v", 64'(valid_out), 64'd1);
        chk("ar_first_i", dout_i, 64'sd10000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rotator.md
# rotator

Synthesizable transmit-side complex rotator: multiplies baseband I/Q samples by e^(+jθ), with θ advanced by an internal phase accumulator. The block drives phase to an external DDS and consumes the returned cos/sin, aligning them internally with the sample stream. It sits between the MSK modulator's baseband output and the DAC path. It is the counterpart of the receive-side derotator, which applies e^(−jθ).

## Interface
- WIDTH, 16: I/Q sample width, signed Q1.(WIDTH−1)
- DDS_WIDTH, 16: cos/sin width, signed Q1.(DDS_WIDTH−1)
- PHASE_WIDTH, 32: phase accumulator/word width, unsigned modulo 2^PHASE_WIDTH
- DDS_LAT, 2: external DDS latency in cycles, from phase_out to cos_in/sin_in (legal 0..8)

Ports (reset: one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- freq_word  in  PHASE_WIDTH  phase increment per valid sample
- phase_offset  in  PHASE_WIDTH  static offset added to accumulator
- phase_load  in  1  pulse: clears accumulator
- valid_in  in  1  din_* qualifier
- din_i, din_q  in  WIDTH signed  baseband sample
- phase_out  out  PHASE_WIDTH  phase request to DDS
- phase_valid  out  1  phase_out qualifier
- cos_in, sin_in  in  DDS_WIDTH signed  DDS result, DDS_LAT cycles after phase_out
- valid_out  out  1  dout_* qualifier
- dout_i, dout_q  out  WIDTH signed  rotated sample

## Operation
- Accumulator acc, PHASE_WIDTH bits, resets to 0.
- On valid_in=1:
  - phase_out ← acc + phase_offset (wraps)
  - phase_valid ← 1
  - acc ← acc + freq_word (wraps)
- On valid_in=0: phase_valid ← 0; phase_out holds; acc holds.
- phase_load=1: acc ← 0. If asserted together with valid_in, the current sample uses phase acc+phase_offset with acc taken before the clear, and acc ← freq_word. phase_load has no other effect.
- The I/Q and valid delay line is DDS_LAT+1 deep, so each sample meets the cos/sin computed from its own phase.
- Multiply stage, registered, with WIDTH+DDS_WIDTH-bit signed products: i·c, q·s, i·s, q·c.
- Sum stage, WIDTH+DDS_WIDTH+1 bits:
  - yi = i·c − q·s
  - yq = i·s + q·c
- Scaling: add 2^(DDS_WIDTH−2), then arithmetic shift right by DDS_WIDTH−1. This is round-half-up.
- Saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1], then register onto dout_*.
- dout_* holds its last value while valid_out=0.
- No backpressure. valid_in may be asserted every cycle or with arbitrary gaps.

## Timing
- valid_in at cycle t produces:
  - phase_out/phase_valid at t+1
  - DDS returns cos/sin at t+1+DDS_LAT
  - multiply registered at t+2+DDS_LAT
  - valid_out and dout_* at t+3+DDS_LAT
- Latency L = DDS_LAT+3 and is fixed. The valid_out pattern equals the valid_in pattern delayed by L.
- cos_in/sin_in are sampled only at delayed-valid cycles; their value at other cycles is don't-care.
- Reset values: acc=0, phase_out=0, phase_valid=0, valid_out=0, dout_i=dout_q=0, all pipeline valids=0.
- Reset asserted mid-stream clears everything immediately and discards in-flight samples; no valid_out follows.
- After rst_n deasserts, the first valid_in uses phase phase_offset.
- Full-scale corner: −2^(WIDTH−1) × −2^(DDS_WIDTH−1) must saturate, not wrap.

## Test plan
All scenarios use WIDTH=16, DDS_WIDTH=16, PHASE_WIDTH=32, DDS_LAT=2, with a behavioural DDS of matching latency.
- Identity: bench DDS forced to cos=32767, sin=0; din=(16384, −8192) -> dout=(16384, −8192) exactly 5 cycles later.
- Quadrature: cos=0, sin=32767; din=(10000, 0) -> dout=(0, 10000).
- Saturation: cos=−32768, sin=0; din=(−32768, −32768) -> dout=(32767, 32767), no wrap to −32768.
- Accumulator wrap: freq_word=0x4000_0000, phase_offset=0x1000_0000, 5 back-to-back valid_in -> phase_out 0x1000_0000, 0x5000_0000, 0x9000_0000, 0xD000_0000, 0x1000_0000.
- Gapped valid plus phase_load:
  - valid_in 1,0,1,1 -> valid_out 1,0,1,1 starting at cycle t+5, and acc advances 3 times.
  - phase_load together with the third valid -> that sample's phase is the pre-clear value; the next sample's phase is freq_word+phase_offset.
- Async reset: drop rst_n for 1 cycle with 4 samples in flight -> all outputs 0 immediately, no valid_out for the flushed samples, and the next sample's phase_out equals phase_offset.
